// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: funct3 codes, FSM encoding
// and the access-size helpers used by the FSM and the lane aligner.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ1  = 3'd1,
        S_WAIT1 = 3'd2,
        S_REQ2  = 3'd3,
        S_WAIT2 = 3'd4,
        S_RESP  = 3'd5
    } lsu_state_e;

    // Byte mask of the access before lane shifting; an illegal size yields no lanes.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_LB, F3_LH, F3_LW: bad = 1'b0;
            F3_LBU, F3_LHU:      bad = is_store;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and store data for both word halves,
// plus extraction and sign/zero extension of the load result.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] load_data
);

    logic [7:0]  be_wide_s;
    logic [63:0] wdata_wide_s;
    logic [63:0] raw_s;

    // Shift the access across an 8-byte window; the upper half is the second word.
    always_comb begin
        be_wide_s    = {4'h0, size_mask(funct3)} << off;
        wdata_wide_s = {32'h0, wdata} << {off, 3'b000};
        raw_s        = {word1, word0} >> {off, 3'b000};
        case (funct3)
            F3_LB:   load_data = {{24{raw_s[7]}}, raw_s[7:0]};
            F3_LH:   load_data = {{16{raw_s[15]}}, raw_s[15:0]};
            F3_LBU:  load_data = {24'h0, raw_s[7:0]};
            F3_LHU:  load_data = {16'h0, raw_s[15:0]};
            default: load_data = raw_s[31:0];
        endcase
    end

    assign be_lo    = be_wide_s[3:0];
    assign be_hi    = be_wide_s[7:4];
    assign wdata_lo = wdata_wide_s[31:0];
    assign wdata_hi = wdata_wide_s[63:32];

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one RV32 op at a time, word-aligned req/gnt/rvalid memory
// transactions, misaligned accesses split into two words (lower word first).
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int SPLIT_MISALIGNED = 1,
    parameter int WAIT_TIMEOUT     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_is_store,
    input  logic [2:0]  op_funct3,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        res_valid,
    output logic [31:0] res_rdata,
    output logic        res_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam bit          SPLIT_EN = (SPLIT_MISALIGNED != 0);
    localparam bit          TO_EN    = (WAIT_TIMEOUT != 0);
    localparam logic [15:0] TO_LIMIT = 16'(WAIT_TIMEOUT - 1);

    lsu_state_e  state_r, state_nxt_s;
    logic        op_store_r, cross_r;
    logic [2:0]  op_f3_r;
    logic [1:0]  op_off_r;
    logic [31:0] op_wdata_r, word0_r;
    logic [15:0] to_cnt_r;

    logic        op_ready_r, res_valid_r, res_err_r, mem_req_r, mem_we_r;
    logic [31:0] res_rdata_r, mem_addr_r, mem_wdata_r;
    logic [3:0]  mem_be_r;

    logic        in_idle_s, accept_s, cross_s, timeout_s, err_nxt_s;
    logic [2:0]  al_f3_s;
    logic [1:0]  al_off_s;
    logic [31:0] al_wdata_s, al_word0_s, al_word1_s;
    logic [3:0]  be_lo_s, be_hi_s;
    logic [31:0] wdata_lo_s, wdata_hi_s, load_data_s;

    // In IDLE the aligner sees the incoming op so REQ1 outputs can be registered at accept.
    assign in_idle_s  = (state_r == S_IDLE);
    assign al_f3_s    = in_idle_s ? op_funct3 : op_f3_r;
    assign al_off_s   = in_idle_s ? op_addr[1:0] : op_off_r;
    assign al_wdata_s = in_idle_s ? op_wdata : op_wdata_r;
    assign al_word0_s = (state_r == S_WAIT1) ? mem_rdata : word0_r;
    assign al_word1_s = (state_r == S_WAIT2) ? mem_rdata : 32'h0;

    lsu_lane_align u_align (
        .funct3    (al_f3_s),
        .off       (al_off_s),
        .wdata     (al_wdata_s),
        .word0     (al_word0_s),
        .word1     (al_word1_s),
        .be_lo     (be_lo_s),
        .be_hi     (be_hi_s),
        .wdata_lo  (wdata_lo_s),
        .wdata_hi  (wdata_hi_s),
        .load_data (load_data_s)
    );

    // Next-state decode and error classification.
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = 1'b0;
        accept_s    = in_idle_s && op_valid;
        cross_s     = |be_hi_s;
        timeout_s   = TO_EN && (to_cnt_r == TO_LIMIT);
        case (state_r)
            S_IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = S_IDLE;
                end else if (f3_illegal(op_is_store, op_funct3) || (cross_s && !SPLIT_EN)) begin
                    state_nxt_s = S_RESP;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = S_REQ1;
                end
            end
            S_REQ1: begin
                if (mem_gnt) state_nxt_s = S_WAIT1;
                else         state_nxt_s = S_REQ1;
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
                    state_nxt_s = cross_r ? S_REQ2 : S_RESP;
                end else if (timeout_s) begin
                    state_nxt_s = S_RESP;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = S_WAIT1;
                end
            end
            S_REQ2: begin
                if (mem_gnt) state_nxt_s = S_WAIT2;
                else         state_nxt_s = S_REQ2;
            end
            S_WAIT2: begin
                if (mem_rvalid) begin
                    state_nxt_s = S_RESP;
                end else if (timeout_s) begin
                    state_nxt_s = S_RESP;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = S_WAIT2;
                end
            end
            S_RESP:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Latched op, first read word and the per-WAIT timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_store_r <= 1'b0;
            op_f3_r    <= 3'b000;
            op_off_r   <= 2'b00;
            op_wdata_r <= 32'h0;
            cross_r    <= 1'b0;
            word0_r    <= 32'h0;
            to_cnt_r   <= 16'h0;
        end else begin
            if (accept_s) begin
                op_store_r <= op_is_store;
                op_f3_r    <= op_funct3;
                op_off_r   <= op_addr[1:0];
                op_wdata_r <= op_wdata;
                cross_r    <= cross_s;
            end
            if ((state_r == S_WAIT1) && mem_rvalid) word0_r <= mem_rdata;
            if (((state_r == S_WAIT1) || (state_r == S_WAIT2)) && (state_nxt_s == state_r))
                to_cnt_r <= to_cnt_r + 16'd1;
            else
                to_cnt_r <= 16'h0;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_ready_r  <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'h0;
            mem_addr_r  <= 32'h0;
            mem_wdata_r <= 32'h0;
            res_valid_r <= 1'b0;
            res_rdata_r <= 32'h0;
            res_err_r   <= 1'b0;
        end else begin
            op_ready_r  <= (state_nxt_s == S_IDLE);
            mem_req_r   <= (state_nxt_s == S_REQ1) || (state_nxt_s == S_REQ2);
            res_valid_r <= (state_nxt_s == S_RESP);
            if (in_idle_s && (state_nxt_s == S_REQ1)) begin
                mem_addr_r  <= {op_addr[31:2], 2'b00};
                mem_we_r    <= op_is_store;
                mem_be_r    <= be_lo_s;
                mem_wdata_r <= wdata_lo_s;
            end else if ((state_r == S_WAIT1) && (state_nxt_s == S_REQ2)) begin
                mem_addr_r  <= mem_addr_r + 32'd4;
                mem_be_r    <= be_hi_s;
                mem_wdata_r <= wdata_hi_s;
            end
            if (state_nxt_s == S_RESP) begin
                res_err_r   <= err_nxt_s;
                res_rdata_r <= (err_nxt_s || op_store_r) ? 32'h0 : load_data_s;
            end
        end
    end

    assign op_ready  = op_ready_r;
    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign mem_we    = mem_we_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;
    assign res_valid = res_valid_r;
    assign res_rdata = res_rdata_r;
    assign res_err   = res_err_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench: a byte-level reference model predicts memory requests and load
// results; monitors compare them whenever the DUT handshakes or completes.
module tb_lsu_mem_master;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } res_t;

    typedef struct {
        logic [31:0] data;
        int          dly;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_ready, op_is_store;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr, op_wdata;
    logic        res_valid, res_err;
    logic [31:0] res_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        op2_valid, op2_ready, op2_is_store;
    logic [2:0]  op2_funct3;
    logic [31:0] op2_addr, op2_wdata;
    logic        res2_valid, res2_err;
    logic [31:0] res2_rdata;
    logic        mem2_req, mem2_gnt, mem2_we, mem2_rvalid;
    logic [31:0] mem2_addr, mem2_wdata, mem2_rdata;
    logic [3:0]  mem2_be;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc, last_res_cyc, res_cnt, gnt2_cyc, req2_cnt;
    bit fast, hold_gnt, hold_rvalid;

    req_t        exp_req_q[$];
    res_t        exp_res_q[$];
    pend_t       pend_q[$];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem_master dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_is_store(op_is_store),
        .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata),
        .res_valid(res_valid), .res_rdata(res_rdata), .res_err(res_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mem_master #(.SPLIT_MISALIGNED(0), .WAIT_TIMEOUT(4)) dut2 (
        .clk(clk), .rst(rst),
        .op_valid(op2_valid), .op_ready(op2_ready), .op_is_store(op2_is_store),
        .op_funct3(op2_funct3), .op_addr(op2_addr), .op_wdata(op2_wdata),
        .res_valid(res2_valid), .res_rdata(res2_rdata), .res_err(res2_err),
        .mem_req(mem2_req), .mem_gnt(mem2_gnt), .mem_addr(mem2_addr), .mem_we(mem2_we),
        .mem_be(mem2_be), .mem_wdata(mem2_wdata), .mem_rvalid(mem2_rvalid), .mem_rdata(mem2_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[31:28]} ^ 8'h96;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] wa);
        if (slv_mem.exists(wa)) return slv_mem[wa];
        return {init_byte(wa + 32'd3), init_byte(wa + 32'd2), init_byte(wa + 32'd1), init_byte(wa)};
    endfunction

    task automatic set_word(input logic [31:0] wa, input logic [31:0] v);
        slv_mem[wa] = v;
        for (int i = 0; i < 4; i++) ref_mem[wa + 32'(i)] = v[8*i +: 8];
    endtask

    // Reference model: walk the accessed bytes one by one and group them by word.
    task automatic model_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
        int n, nreq, lane;
        logic bad;
        logic [31:0] ba, wa, v;
        req_t r [2];
        res_t e;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]);
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (bad) begin
            e.err = 1'b1; e.rdata = 32'h0;
            exp_res_q.push_back(e);
            return;
        end
        nreq = 0; v = 32'h0;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            wa = {ba[31:2], 2'b00};
            lane = int'(ba[1:0]);
            if (nreq == 0 || r[nreq-1].addr != wa) begin
                r[nreq] = '{addr: wa, we: st, be: 4'h0, wdata: 32'h0};
                nreq++;
            end
            r[nreq-1].be[lane] = 1'b1;
            r[nreq-1].wdata[8*lane +: 8] = wd[8*i +: 8];
            if (st) ref_mem[ba] = wd[8*i +: 8];
            else    v[8*i +: 8] = ref_rd(ba);
        end
        if (!st && !f3[2]) begin
            if (n == 1)      v = {{24{v[7]}}, v[7:0]};
            else if (n == 2) v = {{16{v[15]}}, v[15:0]};
        end
        for (int k = 0; k < nreq; k++) exp_req_q.push_back(r[k]);
        e.err = 1'b0; e.rdata = st ? 32'h0 : v;
        exp_res_q.push_back(e);
    endtask

    task automatic drive_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
        int g;
        @(posedge clk); #1;
        op_valid = 1'b1; op_is_store = st; op_funct3 = f3; op_addr = a; op_wdata = wd;
        g = 0;
        @(negedge clk);
        while (!op_ready && g < 200) begin @(negedge clk); g++; end
        acc_cyc = cyc;
        if (!op_ready) check("accept_timeout", 32'(op_ready), 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0; op_funct3 = 3'($urandom); op_addr = $urandom; op_wdata = $urandom;
    endtask

    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        int g;
        model_op(st, f3, a, wd);
        drive_op(st, f3, a, wd);
        g = 0;
        while (exp_res_q.size() != 0 && g < 400) begin @(negedge clk); g++; end
        if (exp_res_q.size() != 0) check("resp_timeout", 32'(exp_res_q.size()), 32'd0);
        #1;
    endtask

    // Memory slave: write on grant, answer each grant with one rvalid after a random delay.
    initial begin
        logic [31:0] w;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req && mem_gnt) begin
                w = slv_rd(mem_addr);
                if (mem_we) begin
                    for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                    slv_mem[mem_addr] = w;
                end
                pend_q.push_back('{data: w, dly: fast ? 0 : int'($urandom_range(0, 3))});
            end
            @(posedge clk); #1;
            mem_gnt    = mem_req && !hold_gnt && (fast || $urandom_range(0, 2) != 0);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (pend_q.size() > 0 && !hold_rvalid) begin
                if (pend_q[0].dly == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_q[0].data;
                    pend_q.delete(0);
                end else begin
                    pend_q[0].dly--;
                end
            end
        end
    end

    // Request monitor.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_gnt) begin
            if (exp_req_q.size() == 0) begin
                check("unexpected_req", 32'(mem_req), 32'd0);
            end else begin
                check("req_addr", mem_addr, exp_req_q[0].addr);
                check("req_we", 32'(mem_we), 32'(exp_req_q[0].we));
                check("req_be", 32'(mem_be), 32'(exp_req_q[0].be));
                if (exp_req_q[0].we)
                    check("req_wdata", mem_wdata & {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}},
                          exp_req_q[0].wdata);
                exp_req_q.delete(0);
            end
        end
    end

    // Stalled requests must not change.
    logic        stall_r = 1'b0;
    logic [68:0] snap_r;
    always @(negedge clk) begin
        if (rst) begin
            stall_r <= 1'b0;
        end else begin
            if (stall_r) begin
                check("req_held", 32'(mem_req), 32'd1);
                check("req_stable", 32'({mem_we, mem_be, mem_addr, mem_wdata} != snap_r), 32'd0);
            end
            stall_r <= mem_req && !mem_gnt;
            snap_r  <= {mem_we, mem_be, mem_addr, mem_wdata};
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            res_cnt      <= res_cnt + 1;
            last_res_cyc <= cyc;
            if (exp_res_q.size() == 0) begin
                check("unexpected_res", 32'(res_valid), 32'd0);
            end else begin
                check("res_err", 32'(res_err), 32'(exp_res_q[0].err));
                check("res_rdata", res_rdata, exp_res_q[0].rdata);
                exp_res_q.delete(0);
            end
        end
    end

    always @(negedge clk) begin
        if (mem2_req && mem2_gnt) begin
            gnt2_cyc <= cyc;
            req2_cnt <= req2_cnt + 1;
        end
    end

    task automatic run2(input logic [2:0] f3, input logic [31:0] a);
        int g;
        @(posedge clk); #1;
        op2_valid = 1'b1; op2_is_store = 1'b0; op2_funct3 = f3; op2_addr = a; op2_wdata = 32'h0;
        g = 0;
        @(negedge clk);
        while (!op2_ready && g < 50) begin @(negedge clk); g++; end
        if (!op2_ready) check("accept2_timeout", 32'(op2_ready), 32'd1);
        @(posedge clk); #1;
        op2_valid = 1'b0;
    endtask

    task automatic wait_res2(output int at);
        int g;
        g = 0;
        @(negedge clk);
        while (!res2_valid && g < 50) begin @(negedge clk); g++; end
        at = cyc;
        if (!res2_valid) check("res2_timeout", 32'(res2_valid), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, t2, g;
        rst = 1'b1; fast = 1'b1; hold_gnt = 1'b0; hold_rvalid = 1'b0;
        res_cnt = 0; req2_cnt = 0; gnt2_cyc = 0; last_res_cyc = 0; acc_cyc = 0;
        op_valid = 1'b0; op_is_store = 1'b0; op_funct3 = 3'b000; op_addr = 32'h0; op_wdata = 32'h0;
        op2_valid = 1'b0; op2_is_store = 1'b0; op2_funct3 = 3'b000; op2_addr = 32'h0; op2_wdata = 32'h0;
        mem2_gnt = 1'b1; mem2_rvalid = 1'b0; mem2_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_rdata", res_rdata, 32'h0);
        check("rst_res_err", 32'(res_err), 32'd0);
        rst = 1'b0;

        // Directed cases with zero-wait memory.
        set_word(32'h10, 32'hDEAD_BEEF);
        do_op(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_latency", 32'(last_res_cyc - acc_cyc), 32'd3);
        check("lw_data", res_rdata, 32'hDEAD_BEEF);
        set_word(32'h10, 32'h8012_3456);
        do_op(1'b0, 3'b000, 32'h13, 32'h0);
        check("lb_data", res_rdata, 32'hFFFF_FF80);
        do_op(1'b0, 3'b100, 32'h13, 32'h0);
        check("lbu_data", res_rdata, 32'h0000_0080);
        do_op(1'b1, 3'b010, 32'h102, 32'h1122_3344);
        check("sw_split_lo", 32'(slv_rd(32'h100) >> 16), 32'h3344);
        check("sw_split_hi", slv_rd(32'h104) & 32'h0000_FFFF, 32'h1122);
        check("sw_latency", 32'(last_res_cyc - acc_cyc), 32'd5);
        set_word(32'h4, 32'hAB00_0000);
        set_word(32'h8, 32'h0000_00CD);
        do_op(1'b0, 3'b001, 32'h7, 32'h0);
        check("lh_split", res_rdata, 32'hFFFF_CDAB);
        do_op(1'b0, 3'b011, 32'h20, 32'h0);
        check("illegal_latency", 32'(last_res_cyc - acc_cyc), 32'd1);
        check("illegal_err", 32'(res_err), 32'd1);
        do_op(1'b1, 3'b100, 32'h20, 32'h5555_AAAA);
        do_op(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);

        // Randomised ops with random grant and rvalid delays.
        fast = 1'b0;
        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                            : (32'h100 + 32'($urandom_range(0, 47)));
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end
        fast = 1'b1;

        // Reset while a request is pending: mem_req must drop immediately.
        hold_gnt = 1'b1;
        drive_op(1'b0, 3'b010, 32'h10, 32'h0);
        @(posedge clk); #3;
        rst = 1'b1; #1;
        check("rst_req1_mem_req", 32'(mem_req), 32'd0);
        check("rst_req1_op_ready", 32'(op_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; hold_gnt = 1'b0;

        // Reset while waiting for rvalid; the late rvalid must not complete anything.
        hold_rvalid = 1'b1;
        model_op(1'b0, 3'b010, 32'h10, 32'h0);
        drive_op(1'b0, 3'b010, 32'h10, 32'h0);
        g = 0;
        while (exp_req_q.size() != 0 && g < 20) begin @(negedge clk); g++; end
        check("wait1_granted", 32'(exp_req_q.size()), 32'd0);
        @(posedge clk); #3;
        check("wait1_busy", 32'(op_ready), 32'd0);
        rst = 1'b1; #1;
        check("rst_wait1_op_ready", 32'(op_ready), 32'd1);
        check("rst_wait1_mem_req", 32'(mem_req), 32'd0);
        exp_res_q.delete();
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        r0 = res_cnt;
        hold_rvalid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("late_rvalid_no_res", 32'(res_cnt), 32'(r0));
        check("late_rvalid_consumed", 32'(pend_q.size()), 32'd0);

        // Second instance: split disabled, four-cycle wait timeout.
        run2(3'b001, 32'h7);
        wait_res2(t2);
        check("nosplit_err", 32'(res2_err), 32'd1);
        check("nosplit_rdata", res2_rdata, 32'h0);
        check("nosplit_no_req", 32'(req2_cnt), 32'd0);
        run2(3'b010, 32'h10);
        wait_res2(t2);
        check("timeout_err", 32'(res2_err), 32'd1);
        check("timeout_rdata", res2_rdata, 32'h0);
        check("timeout_cycles", 32'(t2 - gnt2_cyc), 32'd5);
        check("timeout_one_req", 32'(req2_cnt), 32'd1);
        run2(3'b010, 32'h10);
        g = 0;
        while (req2_cnt < 2 && g < 20) begin @(negedge clk); g++; end
        repeat (3) @(posedge clk);
        #1; mem2_rvalid = 1'b1; mem2_rdata = 32'h1234_5678;
        @(posedge clk); #1; mem2_rvalid = 1'b0; mem2_rdata = 32'h0;
        wait_res2(t2);
        check("slow_rvalid_err", 32'(res2_err), 32'd0);
        check("slow_rvalid_data", res2_rdata, 32'h1234_5678);
        repeat (3) @(posedge clk);
        #1;
        check("res2_held", res2_rdata, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
